// File: rtl/prime_prefetch_pkg.sv
// rtl/prime_prefetch_pkg.sv - shared state encodings and width helpers for prime_prefetch
//
// Purpose: FSM state constants for prime_prefetch and the data-width helper
// shared with the prime generator, so both sides derive WIDTH the same way.
// Ports: none (package).

package prime_prefetch_pkg;

  // FSM state encodings (3-bit, legacy-compatible values)
  localparam logic [2:0] SYNC    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] ERR     = 3'd4;

  // Data width from its log2, identical to the generator's derivation
  function automatic int width_of(input int width_log);
    return 1 << width_log;
  endfunction

endpackage

// File: rtl/prime_prefetch_sfifo.sv
// rtl/prime_prefetch_sfifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: small reusable FWFT FIFO. The head entry is always presented on
// dout; a pop advances to the next entry on the following edge.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, din        write request and data (ignored when full)
//   pop              read request (ignored when empty)
//   dout             head of FIFO, don't-care while empty
//   empty, full      status decoded from the registered count
//   count            registered occupancy, DEPTH_LOG+1 bits

module sfifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG:0]   count
);

  localparam int                   DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG:0]   CNT_FULL = (DEPTH_LOG+1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly DEPTH_LOG bits so they wrap without extra logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/prime_prefetch.sv
// rtl/prime_prefetch.sv - prefetching consumer of the prime generator
//
// Purpose: keeps the prime generator busy by issuing go requests on its own,
// buffers completed primes in an FWFT FIFO and presents them as a
// valid/ready stream. A generator overflow error is made sticky.
// Optional build macro: PRIME_PREFETCH_LEVEL_EN adds the level and hwm ports.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   en                     allow new generator requests
//   gen_go                 one-cycle request pulse to the generator
//   gen_ready, gen_error   generator idle/result valid, overflow flag
//   gen_res                generator result
//   out_valid, out_ready   output stream handshake
//   out_data               head of FIFO
//   out_err                sticky generator error
//   level, hwm             FIFO occupancy and its high-water mark (macro only)

module prime_prefetch
  import prime_prefetch_pkg::*;
#(
  parameter  int WIDTH_LOG = 4,
  parameter  int DEPTH_LOG = 2,
  localparam int WIDTH     = width_of(WIDTH_LOG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               gen_go,
  input  logic               gen_ready,
  input  logic               gen_error,
  input  logic [WIDTH-1:0]   gen_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err
`ifdef PRIME_PREFETCH_LEVEL_EN
  ,
  output logic [DEPTH_LOG:0] level,
  output logic [DEPTH_LOG:0] hwm
`endif
);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic               go_nxt;
  logic               err_set;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic [DEPTH_LOG:0] count;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // Only one request is ever in flight and an issue needs a free slot
  // (judged on the registered count), so a push can never find the FIFO full.
  always_comb begin
    state_nxt = state;
    go_nxt    = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    case (state)
      // First ready after reset carries the generator's reset value; drop it
      SYNC:    if (gen_ready) state_nxt = ISSUE;
      ISSUE:   if (en && !full && gen_ready) begin
                 go_nxt    = 1'b1;
                 state_nxt = WAIT_LO;
               end
      WAIT_LO: if (!gen_ready) state_nxt = WAIT_HI;
      WAIT_HI: if (gen_ready) begin
                 if (gen_error) begin
                   err_set   = 1'b1;
                   state_nxt = ERR;
                 end else begin
                   push      = 1'b1;
                   state_nxt = ISSUE;
                 end
               end
      ERR:     state_nxt = ERR;
      default: state_nxt = 3'bx;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      gen_go  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      gen_go <= go_nxt;
      if (err_set) out_err <= 1'b1;
    end
  end

  sfifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (gen_res),
    .dout  (out_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

`ifdef PRIME_PREFETCH_LEVEL_EN
  assign level = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm <= '0;
    end else if (count > hwm) begin
      hwm <= count;
    end
  end
`endif

endmodule
